// File: rtl/adbg_or1k_run_ctrl.sv
// adbg_or1k_run_ctrl: multi-core run control for the debug interface.
// Each core has a RUN/HALT/STEP state machine, a halt-cause code and a step
// counter. A one-entry command register takes commands from the debug
// module, and a cross-trigger group halts every member core when any member
// hits a breakpoint.
module adbg_or1k_run_ctrl #(
  parameter int NB_CORES = 4,
  parameter int STEP_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_op_i,
  input  logic [NB_CORES-1:0]   cmd_mask_i,
  input  logic [STEP_W-1:0]     cmd_arg_i,
  input  logic [NB_CORES-1:0]   bp_i,
  input  logic [NB_CORES-1:0]   retire_i,
  output logic [NB_CORES-1:0]   cpu_stall_o,
  output logic [NB_CORES-1:0]   halted_o,
  output logic [2*NB_CORES-1:0] cause_o,
  output logic [NB_CORES-1:0]   xtrig_mask_o,
  output logic                  halt_evt_o
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_XTRIG  = 3'd4;
  localparam logic [2:0] OP_CLEAR  = 3'd5;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HOST = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_XT   = 2'b11;

  // Command register
  logic                cmd_full_q;
  logic [2:0]          cmd_op_q;
  logic [NB_CORES-1:0] cmd_mask_q;
  logic [STEP_W-1:0]   cmd_arg_q;

  // Per-core state
  logic [1:0]          state_q [NB_CORES];
  logic [1:0]          state_d [NB_CORES];
  logic [1:0]          cause_q [NB_CORES];
  logic [1:0]          cause_d [NB_CORES];
  logic [STEP_W-1:0]   cnt_q   [NB_CORES];
  logic [STEP_W-1:0]   cnt_d   [NB_CORES];

  logic [NB_CORES-1:0] xtrig_mask_q;
  logic [NB_CORES-1:0] halted_prev_q;
  logic                halt_evt_q;
  logic [NB_CORES-1:0] halted;
  logic [NB_CORES-1:0] xt_hit_vec;
  logic [NB_CORES-1:0] cmd_moved;
  logic                xt_hit;

  assign cmd_ready_o = ~cmd_full_q;

  // Capture one command; a full register is always applied on the next edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_full_q <= 1'b0;
      cmd_op_q   <= '0;
      cmd_mask_q <= '0;
      cmd_arg_q  <= '0;
    end else if (cmd_full_q) begin
      cmd_full_q <= 1'b0;
    end else if (cmd_valid_i) begin
      // NOTE: registered state is updated with <= so every flop samples the
      // pre-edge values of its neighbours, exactly like the hardware.
      cmd_full_q <= 1'b1;
      cmd_op_q   <= cmd_op_i;
      cmd_mask_q <= cmd_mask_i;
      cmd_arg_q  <= cmd_arg_i;
    end
  end

  // Cross-trigger detection and the combinational stall terms.
  always_comb begin
    xt_hit     = |(bp_i & xtrig_mask_q);
    xt_hit_vec = xtrig_mask_q & {NB_CORES{xt_hit}};
    for (int i = 0; i < NB_CORES; i++) begin
      halted[i]           = (state_q[i] == ST_HALT);
      cause_o[2*i +: 2]   = cause_q[i];
    end
    cpu_stall_o = halted | bp_i | xt_hit_vec;
  end

  // Per-core next state: breakpoint, then cross-trigger, then command, then step.
  always_comb begin
    for (int i = 0; i < NB_CORES; i++) begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and no latch is inferred.
      state_d[i]   = state_q[i];
      cause_d[i]   = cause_q[i];
      cnt_d[i]     = cnt_q[i];
      cmd_moved[i] = 1'b0;
      if (bp_i[i]) begin
        state_d[i] = ST_HALT;
        cause_d[i] = CAUSE_BP;
        cnt_d[i]   = '0;
      end else if (xt_hit_vec[i]) begin
        // A core already halted stays halted and keeps its original cause.
        if (state_q[i] != ST_HALT) begin
          state_d[i] = ST_HALT;
          cause_d[i] = CAUSE_XT;
          cnt_d[i]   = '0;
        end
      end else begin
        if (cmd_full_q && cmd_mask_q[i]) begin
          case (cmd_op_q)
            OP_HALT: if (state_q[i] != ST_HALT) begin
              state_d[i]   = ST_HALT;
              cause_d[i]   = CAUSE_HOST;
              cnt_d[i]     = '0;
              cmd_moved[i] = 1'b1;
            end
            OP_RESUME: if (state_q[i] == ST_HALT) begin
              state_d[i]   = ST_RUN;
              cmd_moved[i] = 1'b1;
            end
            OP_STEP: if (state_q[i] == ST_HALT && cmd_arg_q != '0) begin
              state_d[i]   = ST_STEP;
              cnt_d[i]     = cmd_arg_q;
              cmd_moved[i] = 1'b1;
            end
            OP_CLEAR: cause_d[i] = CAUSE_NONE;
            default: ;
          endcase
        end
        // A cause clear does not move the core, so a retire in that cycle still counts.
        if (!cmd_moved[i] && state_q[i] == ST_STEP && retire_i[i]) begin
          if (cnt_q[i] == STEP_W'(1)) begin
            state_d[i] = ST_HALT;
            cause_d[i] = CAUSE_HOST;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - STEP_W'(1);
          end
        end
      end
    end
  end

  // Per-core state, cause and step counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: these arrays are a handful of flops per core, not a RAM, so
      // resetting every entry is cheap and gives a defined start state.
      for (int i = 0; i < NB_CORES; i++) begin
        state_q[i] <= ST_RUN;
        cause_q[i] <= CAUSE_NONE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        state_q[i] <= state_d[i];
        cause_q[i] <= cause_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Cross-trigger group register and halt-entry event pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xtrig_mask_q  <= '0;
      halted_prev_q <= '0;
      halt_evt_q    <= 1'b0;
    end else begin
      if (cmd_full_q && cmd_op_q == OP_XTRIG) xtrig_mask_q <= cmd_mask_q;
      halted_prev_q <= halted;
      halt_evt_q    <= |(halted & ~halted_prev_q);
    end
  end

  assign halted_o     = halted;
  assign xtrig_mask_o = xtrig_mask_q;
  assign halt_evt_o   = halt_evt_q;

endmodule

// File: doc/adbg_or1k_run_ctrl.md
# adbg_or1k_run_ctrl

Multi-core run-control block for the debug interface: per-core halt/resume/single-step state machines, breakpoint latching with halt-cause recording, and a cross-trigger group that halts every member core when any member hits a breakpoint. It sits in the CPU clock domain between the debug module's command path, already synchronised into this domain, and the cores' stall inputs. It generalises the stall/breakpoint status register with step counting, cause tracking and cross-triggering.

## Interface
- NB_CORES, 4, number of controlled cores (1..32)
- STEP_W, 8, width of the step counter and the step-count argument
- clk_i  in  1  CPU clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready at a rising edge
- cmd_op_i  in  3  0 NOP, 1 HALT, 2 RESUME, 3 STEP, 4 SET_XTRIG, 5 CLEAR_CAUSE, 6-7 treated as NOP
- cmd_mask_i  in  NB_CORES  target cores
- cmd_arg_i  in  STEP_W  step count (STEP only)
- bp_i  in  NB_CORES  per-core breakpoint, level
- retire_i  in  NB_CORES  per-core instruction-retired pulse
- cpu_stall_o  out  NB_CORES  stall to cores
- halted_o  out  NB_CORES  core is in HALT state (registered)
- cause_o  out  2*NB_CORES  per-core halt cause, core i at [2i+1:2i]: 00 none, 01 host/step, 10 breakpoint, 11 cross-trigger
- xtrig_mask_o  out  NB_CORES  current cross-trigger group
- halt_evt_o  out  1  one-cycle pulse when at least one core entered HALT on the previous edge

## Operation
- Per-core FSM states: RUN, HALT, STEP. Reset state is RUN.
- Command path has a one-entry register. Accept when valid & ready. The command is applied on the next edge. cmd_ready_o is low in the cycle the register is full, so sustained throughput is one command per 2 cycles.
- xt_hit = |(bp_i & xtrig_mask). Core i is xtrig-hit when xtrig_mask[i] & xt_hit.
- Per-core priority on every edge, highest first:
  1. bp_i[i]: go to HALT, cause 10. Applies from any state.
  2. xtrig-hit and not bp_i[i]: go to HALT, cause 11. Applies from RUN or STEP. A core already in HALT keeps its cause.
  3. Applied command with mask[i] set:
     - HALT: RUN/STEP go to HALT, cause 01, step counter cleared. Already in HALT: no change.
     - RESUME: HALT goes to RUN. Cause is kept.
     - STEP, arg N: HALT with N>0 goes to STEP with cnt=N. N=0, or core not in HALT: no effect.
     - CLEAR_CAUSE: cause set to 00. State unchanged.
  4. In STEP, retire_i[i]: cnt decrements. A retire while cnt==1 goes to HALT, cause 01.
- SET_XTRIG loads xtrig_mask from cmd_mask_i. It ignores per-core state.
- cpu_stall_o[i] = halted[i] | bp_i[i] | (xtrig_mask[i] & xt_hit). The two event terms are combinational, so they stall immediately, in the same cycle as the breakpoint.
- halt_evt_o is registered: set when any core made a non-HALT to HALT transition on the previous edge.

## Timing
- Reset values:
  - all cores in RUN; cause 00; cnt 0
  - xtrig_mask_o 0, halted_o 0, halt_evt_o 0
  - cmd_ready_o 1; command register empty
  - cpu_stall_o = bp_i | (xtrig_mask & xt_hit), which is 0 while bp_i=0
- Reset asserted mid-step or mid-command: all state returns to reset values immediately. A pending command is dropped.
- Command latency:
  - accepted at edge N, applied at edge N+1
  - halted_o, cause_o and the registered stall term change after N+1
  - cmd_ready_o is low between N and N+1
- Breakpoint: bp_i high before edge N.
  - cpu_stall_o high combinationally in the same cycle
  - halted_o=1 and cause=10 after edge N
  - halt_evt_o high for the cycle after N+1
- Step: the Nth retire pulse sampled at edge M gives halted_o=1 after M. The core runs with stall low from the STEP application edge until M.
- bp_i and an applied RESUME for the same core on the same edge: the core stays in HALT with cause 10.

## Test plan
- Reset, NB_CORES=4, no stimulus -> cpu_stall_o=0000, halted_o=0000, cause_o=0, cmd_ready_o=1, xtrig_mask_o=0000.
- HALT mask=0101 accepted at edge N -> cmd_ready_o=0 until N+1; halted_o=0101, cause 01 on cores 0 and 2 after N+1; halt_evt_o one-cycle pulse; RESUME mask=0001 -> halted_o=0100, core 0 cause stays 01.
- Core 1 halted, STEP arg=3, three retire_i[1] pulses spaced 2 cycles apart -> cpu_stall_o[1]=0 until the third pulse's edge, then halted_o[1]=1, cause 01. STEP arg=0 -> no change.
- SET_XTRIG 1011, bp_i[3] one-cycle pulse -> cpu_stall_o=1011 in the same cycle; halted_o=1011 next edge; causes: core3 10, cores 0 and 1 11, core2 00.
- Core 2 in STEP with cnt=5, bp_i[2] and HALT on the same edge -> HALT with cause 10, cnt cleared; following CLEAR_CAUSE mask=0100 -> cause 00, halted_o[2] stays 1.
- rst_i asserted while core 0 is in STEP and a command is pending -> all outputs at reset values immediately; after release a new command is accepted on the first edge.
